// File: rtl/uart_pkg.sv
// Shared UART types: data length, stop bits, parity mode and transmitter FSM states.
// Also holds the parity helper that the transmitter uses when it latches a byte.
package uart_pkg;

  typedef enum logic [1:0] {DBIT5, DBIT6, DBIT7, DBIT8} uart_data_lenght_t;
  typedef enum logic {STOP1, STOP2} uart_stop_bits_t;
  typedef enum logic {EVEN, ODD} uart_parity_mode_t;
  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP, BREAK} uart_tx_state_t;

  // Only the first 5+len bits count; ODD starts the XOR at 1 to invert the result.
  function automatic logic tx_parity(input logic [7:0] data,
                                     input uart_data_lenght_t len,
                                     input uart_parity_mode_t mode);
    logic p;
    p = (mode == ODD);
    for (int i = 0; i < 8; i++) begin
      if (i < 5 + int'(len)) p ^= data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_generator.sv
// Baud tick generator: one-cycle tick every divider_i+1 clocks; clear_i restarts the period.
// The divider is re-sampled on clear and at every wrap, so a live change takes effect next period.
module uart_baud_generator (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [14:0] divider_i,
  output logic        tick_o
);

  logic [14:0] r_cnt;
  logic [14:0] r_div;
  logic        w_wrap;

  assign w_wrap = (r_cnt == r_div);
  assign tick_o = ~clear_i & w_wrap;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_div <= '0;
    end else if (clear_i || w_wrap) begin
      r_cnt <= '0;
      r_div <= divider_i;
    end else begin
      r_cnt <= r_cnt + 15'd1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start, 5-8 data bits LSB first, optional parity, 1/2 stop bits, OVERSAMPLE ticks per bit.
// Optional line break (port break_i, state BREAK) when UART_TX_BREAK_EN is defined.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_empty_i,
  output logic        tx_fetch_o,
  input  logic        enable_i,
  input  logic        flow_control_i,
  input  logic        cts_i,
  input  logic [1:0]  data_lenght_i,
  input  logic        stop_bits_i,
  input  logic        parity_enable_i,
  input  logic        parity_mode_i,
  input  logic [14:0] divider_i,
  output logic        tx_o,
  output logic        tx_done_o,
  output logic        busy_o
`ifdef UART_TX_BREAK_EN
  ,
  input  logic        break_i
`endif
);

  localparam int OS_W = $clog2(OVERSAMPLE);

  uart_tx_state_t r_state;
  logic            r_cts_meta, r_cts_sync;
  logic [OS_W-1:0] r_os_cnt;
  logic [2:0]      r_bit_cnt, r_last_bit;
  logic [7:0]      r_shift;
  logic            r_parity_en, r_parity, r_two_stop, r_stop_cnt, r_frame;
  logic            r_tx, r_done;
  logic            w_tick, w_bit_end, w_start, w_break, w_clear;

`ifdef UART_TX_BREAK_EN
  assign w_break = break_i;
`else
  assign w_break = 1'b0;
`endif

  assign w_start    = enable_i & ~tx_empty_i & (~flow_control_i | r_cts_sync);
  assign tx_fetch_o = (r_state == IDLE) & w_start & ~w_break;
  assign w_clear    = (r_state == IDLE) | (r_state == FETCH);
  assign w_bit_end  = w_tick & (r_os_cnt == OS_W'(OVERSAMPLE - 1));
  assign tx_o       = r_tx;
  assign tx_done_o  = r_done;
  assign busy_o     = (r_state != IDLE);

  uart_baud_generator u_baud (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (w_clear),
    .divider_i (divider_i),
    .tick_o    (w_tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cts_meta <= 1'b0;
      r_cts_sync <= 1'b0;
    end else begin
      r_cts_meta <= cts_i;
      r_cts_sync <= r_cts_meta;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_os_cnt    <= '0;
      r_bit_cnt   <= '0;
      r_last_bit  <= '0;
      r_shift     <= '0;
      r_parity_en <= 1'b0;
      r_parity    <= 1'b0;
      r_two_stop  <= 1'b0;
      r_stop_cnt  <= 1'b0;
      r_frame     <= 1'b0;
      r_tx        <= 1'b1;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Oversample counter wraps to 0 on every bit boundary by width.
      if (w_tick) r_os_cnt <= r_os_cnt + OS_W'(1);
      case (r_state)
        IDLE: begin
          r_os_cnt <= '0;
          r_tx     <= 1'b1;
          if (w_break) begin
            r_state <= BREAK;
            r_frame <= 1'b0;
            r_tx    <= 1'b0;
          end else if (w_start) begin
            r_state <= FETCH;
          end
        end
        FETCH: begin
          r_os_cnt    <= '0;
          r_shift     <= tx_data_i;
          r_last_bit  <= 3'd4 + {1'b0, data_lenght_i};
          r_parity    <= tx_parity(tx_data_i, uart_data_lenght_t'(data_lenght_i),
                                   uart_parity_mode_t'(parity_mode_i));
          r_parity_en <= parity_enable_i;
          r_two_stop  <= (uart_stop_bits_t'(stop_bits_i) == STOP2);
          r_stop_cnt  <= 1'b0;
          r_bit_cnt   <= '0;
          r_frame     <= 1'b1;
          r_tx        <= 1'b0;
          r_state     <= START;
        end
        START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_state <= DATA;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bit_cnt == r_last_bit) begin
              r_tx    <= r_parity_en ? r_parity : 1'b1;
              r_state <= r_parity_en ? PARITY : STOP;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (r_two_stop && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else begin
              r_done  <= r_frame;
              r_state <= IDLE;
            end
          end
        end
        BREAK: begin
          if (w_bit_end && !w_break) begin
            r_tx       <= 1'b1;
            r_two_stop <= 1'b0;
            r_stop_cnt <= 1'b0;
            r_state    <= STOP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: directed frames from the datasheet plus randomized frames
// compared cycle by cycle against an expected-bit queue built from the frame format.
module tb_uart_transmitter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  tx_data_i = 8'h00;
  logic        tx_empty_i = 1'b1;
  logic        tx_fetch_o;
  logic        enable_i = 1'b1;
  logic        flow_control_i = 1'b0;
  logic        cts_i = 1'b0;
  logic [1:0]  data_lenght_i = 2'd3;
  logic        stop_bits_i = 1'b0;
  logic        parity_enable_i = 1'b0;
  logic        parity_mode_i = 1'b0;
  logic [14:0] divider_i = 15'd0;
  logic        tx_o, tx_done_o, busy_o;
  logic        break_i = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          fetch_cnt = 0;
  logic [7:0]  q[$];

  uart_transmitter #(.OVERSAMPLE(16)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .tx_data_i       (tx_data_i),
    .tx_empty_i      (tx_empty_i),
    .tx_fetch_o      (tx_fetch_o),
    .enable_i        (enable_i),
    .flow_control_i  (flow_control_i),
    .cts_i           (cts_i),
    .data_lenght_i   (data_lenght_i),
    .stop_bits_i     (stop_bits_i),
    .parity_enable_i (parity_enable_i),
    .parity_mode_i   (parity_mode_i),
    .divider_i       (divider_i),
    .tx_o            (tx_o),
    .tx_done_o       (tx_done_o),
    .busy_o          (busy_o)
`ifdef UART_TX_BREAK_EN
    ,
    .break_i         (break_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // FIFO model: pop on a fetch pulse, present the word the cycle after.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (tx_fetch_o === 1'b1) begin
        fetch_cnt++;
        @(posedge clk_i);
        #1;
        if (q.size() > 0) tx_data_i = q.pop_front();
        tx_empty_i = (q.size() == 0);
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    tx_empty_i = 1'b0;
  endtask

  task automatic set_cfg(input int n, input bit s2, input bit pen, input bit podd);
    data_lenght_i   = 2'(n - 5);
    stop_bits_i     = s2;
    parity_enable_i = pen;
    parity_mode_i   = podd;
  endtask

  // Waits (bounded) for the start bit, then checks every clock of the frame against the reference bits.
  task automatic expect_frame(input logic [7:0] d, input int n, input bit s2, input bit pen,
                              input bit podd, input int div, input bit scramble,
                              input bit drop_cts, output int gap);
    bit         exp_bits[$];
    logic [7:0] m;
    int         bit_len, total, t, bad_tx, bad_done, bad_busy;
    bit         exp_tx;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) exp_bits.push_back(d[i]);
    m = 8'((1 << n) - 1);
    if (pen) exp_bits.push_back(((($countones(d & m) % 2) == 1) ? 1'b1 : 1'b0) ^ podd);
    exp_bits.push_back(1'b1);
    if (s2) exp_bits.push_back(1'b1);
    bit_len = 16 * (div + 1);
    total   = exp_bits.size() * bit_len;
    t = 0;
    while (tx_o !== 1'b0 && t < 1000) begin
      @(negedge clk_i);
      t++;
    end
    gap = t;
    if (tx_o !== 1'b0) begin
      check("start_bit_seen", 0, 1);
      return;
    end
    if (scramble) begin
      data_lenght_i   = 2'($urandom);
      stop_bits_i     = 1'($urandom);
      parity_enable_i = 1'($urandom);
      parity_mode_i   = 1'($urandom);
    end
    if (drop_cts) cts_i = 1'b0;
    bad_tx = 0; bad_done = 0; bad_busy = 0;
    for (int c = 0; c <= total; c++) begin
      if (c > 0) @(negedge clk_i);
      exp_tx = (c < total) ? exp_bits[c / bit_len] : 1'b1;
      if (tx_o !== exp_tx) bad_tx++;
      if (tx_done_o !== (c == total)) bad_done++;
      if (busy_o !== (c < total)) bad_busy++;
    end
    check("frame_bits_bad_cycles", bad_tx, 0);
    check("done_pulse_bad_cycles", bad_done, 0);
    check("busy_bad_cycles", bad_busy, 0);
  endtask

  initial begin
    int f0, gap, lows, busys, dones, lat, n;
    bit s2, pen, podd;
    logic [7:0] b;

    repeat (3) @(negedge clk_i);
    check("reset_tx", tx_o, 1);
    check("reset_fetch", tx_fetch_o, 0);
    check("reset_done", tx_done_o, 0);
    check("reset_busy", busy_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    set_cfg(8, 0, 0, 0);
    f0 = fetch_cnt;
    push(8'h55);
    expect_frame(8'h55, 8, 0, 0, 0, 0, 1, 0, gap);
    check("start_latency", gap, 2);
    check("fetch_8n1", fetch_cnt - f0, 1);

    set_cfg(7, 1, 1, 0);
    push(8'h83);
    expect_frame(8'h83, 7, 1, 1, 0, 0, 1, 0, gap);

    set_cfg(5, 0, 1, 1);
    push(8'h1F);
    expect_frame(8'h1F, 5, 0, 1, 1, 0, 1, 0, gap);

    set_cfg(5, 0, 1, 0);
    push(8'h1F);
    expect_frame(8'h1F, 5, 0, 1, 0, 0, 0, 0, gap);

    set_cfg(8, 0, 0, 0);
    push(8'hA5);
    push(8'h3C);
    expect_frame(8'hA5, 8, 0, 0, 0, 0, 0, 0, gap);
    expect_frame(8'h3C, 8, 0, 0, 0, 0, 0, 0, gap);
    check("back_to_back_gap", gap, 2);

    for (int k = 0; k < 12; k++) begin
      n    = 5 + int'($urandom_range(0, 3));
      s2   = 1'($urandom);
      pen  = 1'($urandom);
      podd = 1'($urandom);
      b    = 8'($urandom);
      divider_i = 15'($urandom_range(0, 2));
      set_cfg(n, s2, pen, podd);
      push(b);
      expect_frame(b, n, s2, pen, podd, int'(divider_i), 1, 0, gap);
    end
    divider_i = 15'd0;

    set_cfg(8, 0, 0, 0);
    flow_control_i = 1'b1;
    cts_i = 1'b0;
    f0 = fetch_cnt;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) lows++;
    end
    check("flow_no_fetch", fetch_cnt - f0, 0);
    check("flow_line_idle", lows, 0);
    cts_i = 1'b1;
    lat = 0;
    while (tx_fetch_o !== 1'b1 && lat < 10) begin
      @(negedge clk_i);
      lat++;
    end
    check("cts_sync_latency", lat, 2);
    expect_frame(8'h11, 8, 0, 0, 0, 0, 0, 1, gap);
    repeat (50) @(negedge clk_i);
    check("cts_drop_fetches", fetch_cnt - f0, 1);
    check("cts_drop_queue", q.size(), 2);
    q.delete();
    tx_empty_i = 1'b1;
    flow_control_i = 1'b0;

    divider_i = 15'd3;
    push(8'hC6);
    expect_frame(8'hC6, 8, 0, 0, 0, 3, 1, 0, gap);

    set_cfg(8, 0, 0, 0);
    f0 = fetch_cnt;
    push(8'h5A);
    lat = 0;
    while (tx_o !== 1'b0 && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
    repeat (64 + 40) @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("async_reset_tx", tx_o, 1);
    check("async_reset_busy", busy_o, 0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    dones = 0; lows = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk_i);
      if (tx_done_o === 1'b1) dones++;
      if (tx_o !== 1'b1) lows++;
    end
    check("reset_no_done", dones, 0);
    check("reset_byte_lost", lows, 0);
    check("reset_fetches", fetch_cnt - f0, 1);
    divider_i = 15'd0;

`ifdef UART_TX_BREAK_EN
    f0 = fetch_cnt;
    lows = 0; busys = 0; dones = 0;
    break_i = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk_i);
      if (i == 39) break_i = 1'b0;
      if (tx_o === 1'b0) lows++;
      if (busy_o === 1'b1) busys++;
      if (tx_done_o === 1'b1) dones++;
    end
    check("break_low_clocks", lows, 48);
    check("break_busy_clocks", busys, 64);
    check("break_no_done", dones, 0);
    check("break_no_fetch", fetch_cnt - f0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
